// File: rtl/ann_io_pkg.sv
// Shared constants for the ANN accelerator pad responder: mode codes,
// control FSM states and error flag positions.
package ann_io_pkg;

    localparam int DATA_W_DEFAULT = 11;

    localparam logic [1:0] MODE_QUERY = 2'b00;
    localparam logic [1:0] MODE_LOAD  = 2'b01;
    localparam logic [1:0] MODE_SEND  = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int ERR_IN_OVF     = 0;
    localparam int ERR_RD_EMPTY   = 1;
    localparam int ERR_START_BUSY = 2;

    // load_kdtree has priority over send_best_arr when both are raised.
    function automatic logic [1:0] pick_mode(input logic load, input logic send);
        if (load)
            return MODE_LOAD;
        else if (send)
            return MODE_SEND;
        else
            return MODE_QUERY;
    endfunction

endpackage

// File: rtl/ann_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy outputs and a peek at the entry
// behind the head, so a consumer can register the post-pop head word.
module ann_sync_fifo #(
    parameter int W     = 11,
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [W-1:0]            wdata,
    input  logic                    pop,
    output logic [W-1:0]            rdata,
    output logic [W-1:0]            rdata_next,
    output logic [$clog2(DEPTH):0]  count,
    output logic [$clog2(DEPTH):0]  count_next,
    output logic                    overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW:0]   wptr, rptr, wptr_n, rptr_n;
    logic          empty, full, do_push, do_pop, bypass;
    logic [AW-1:0] ridx_next;

    assign empty     = (wptr == rptr);
    assign full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop    = pop && !empty;
    // Push and pop on an empty FIFO hand the word straight through.
    assign bypass    = push && pop && empty;
    assign do_push   = push && !bypass && (!full || do_pop);
    assign overflow  = push && full && !do_pop;

    assign wptr_n     = wptr + (AW+1)'(do_push);
    assign rptr_n     = rptr + (AW+1)'(do_pop);
    assign count      = wptr - rptr;
    assign count_next = wptr_n - rptr_n;

    assign ridx_next  = rptr[AW-1:0] + AW'(1);
    assign rdata      = empty ? wdata : mem[rptr[AW-1:0]];
    assign rdata_next = mem[ridx_next];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wptr[AW-1:0]] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            wptr <= wptr_n;
            rptr <= rptr_n;
        end
    end

endmodule

// File: rtl/ann_io_port.sv
// Chip-side responder for the ANN accelerator pad protocol: input FIFO (host
// to core), output FIFO (core to host) and the start/mode/done control FSM.
module ann_io_port
    import ann_io_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEFAULT,
    parameter int IN_DEPTH  = 16,
    parameter int OUT_DEPTH = 16
) (
    input  logic              io_clk,
    input  logic              io_rst,
    input  logic              in_fifo_wenq,
    input  logic [DATA_W-1:0] in_fifo_wdata,
    output logic              in_fifo_wfull_n,
    input  logic              out_fifo_deq,
    output logic [DATA_W-1:0] out_fifo_rdata,
    output logic              out_fifo_rempty_n,
    input  logic              fsm_start,
    input  logic              load_kdtree,
    input  logic              send_best_arr,
    output logic              fsm_done,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_rvalid,
    input  logic              core_rdeq,
    input  logic [DATA_W-1:0] core_wdata,
    input  logic              core_wenq,
    output logic              core_wready,
    output logic              core_start,
    output logic [1:0]        core_mode,
    input  logic              core_done,
    output logic [2:0]        err,
    output state_t            fsm_state
);

    // Core handshakes: a word moves on a rising edge where core_rvalid&&core_rdeq
    // (input FIFO) or core_wready&&core_wenq (output FIFO); valid never waits on ready.

    localparam int IN_AW  = $clog2(IN_DEPTH);
    localparam int OUT_AW = $clog2(OUT_DEPTH);

    logic              wenq_r, deq_r, start_r, start_prev, load_r, send_r;
    logic [DATA_W-1:0] wdata_r;
    logic              start_edge;
    state_t            state;

    logic [IN_AW:0]    in_count, in_count_next;
    logic [IN_AW+1:0]  in_used;
    logic              in_ovf;
    logic [DATA_W-1:0] in_peek_unused;

    logic              out_push, out_pop;
    logic [DATA_W-1:0] out_head, out_peek;
    logic [OUT_AW:0]   out_count, out_count_next, out_remain;
    logic              out_ovf_unused;

    always_ff @(posedge io_clk or posedge io_rst) begin
        if (io_rst) begin
            wenq_r     <= 1'b0;
            wdata_r    <= '0;
            deq_r      <= 1'b0;
            start_r    <= 1'b0;
            start_prev <= 1'b0;
            load_r     <= 1'b0;
            send_r     <= 1'b0;
        end else begin
            wenq_r     <= in_fifo_wenq;
            wdata_r    <= in_fifo_wdata;
            deq_r      <= out_fifo_deq;
            start_r    <= fsm_start;
            start_prev <= start_r;
            load_r     <= load_kdtree;
            send_r     <= send_best_arr;
        end
    end

    assign start_edge = start_r && !start_prev;

    ann_sync_fifo #(.W(DATA_W), .DEPTH(IN_DEPTH)) u_in_fifo (
        .clk        (io_clk),
        .rst        (io_rst),
        .push       (wenq_r),
        .wdata      (wdata_r),
        .pop        (core_rdeq),
        .rdata      (core_rdata),
        .rdata_next (in_peek_unused),
        .count      (in_count),
        .count_next (in_count_next),
        .overflow   (in_ovf)
    );

    assign core_rvalid = (in_count != '0);

    // The word entering the pad register this edge is already committed, so it
    // counts as used; deassert while fewer than three entries remain free.
    assign in_used = {1'b0, in_count_next} + (IN_AW+2)'(in_fifo_wenq);

    always_ff @(posedge io_clk or posedge io_rst) begin
        if (io_rst)
            in_fifo_wfull_n <= 1'b0;
        else
            in_fifo_wfull_n <= (in_used < (IN_AW+2)'(IN_DEPTH - 2));
    end

    assign out_push = core_wenq && core_wready;
    assign out_pop  = deq_r && out_fifo_rempty_n;

    ann_sync_fifo #(.W(DATA_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
        .clk        (io_clk),
        .rst        (io_rst),
        .push       (out_push),
        .wdata      (core_wdata),
        .pop        (out_pop),
        .rdata      (out_head),
        .rdata_next (out_peek),
        .count      (out_count),
        .count_next (out_count_next),
        .overflow   (out_ovf_unused)
    );

    // Occupancy after this edge's pop but before its push: a fresh core word
    // becomes visible to the host one edge after it lands.
    assign out_remain = out_count - (OUT_AW+1)'(out_pop);

    always_ff @(posedge io_clk or posedge io_rst) begin
        if (io_rst) begin
            out_fifo_rempty_n <= 1'b0;
            out_fifo_rdata    <= '0;
            core_wready       <= 1'b0;
        end else begin
            out_fifo_rempty_n <= (out_remain != '0);
            if (out_remain != '0)
                out_fifo_rdata <= out_pop ? out_peek : out_head;
            core_wready       <= (out_count_next != (OUT_AW+1)'(OUT_DEPTH));
        end
    end

    always_ff @(posedge io_clk or posedge io_rst) begin
        if (io_rst) begin
            state      <= IDLE;
            core_start <= 1'b0;
            core_mode  <= MODE_QUERY;
            fsm_done   <= 1'b0;
        end else begin
            core_start <= 1'b0;
            fsm_done   <= (state == DONE);
            case (state)
                IDLE, DONE: begin
                    if (start_edge) begin
                        state      <= BUSY;
                        core_start <= 1'b1;
                        core_mode  <= pick_mode(load_r, send_r);
                    end
                end
                BUSY: begin
                    if (core_done)
                        state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign fsm_state = state;

    always_ff @(posedge io_clk or posedge io_rst) begin
        if (io_rst) begin
            err <= '0;
        end else begin
            if (in_ovf)
                err[ERR_IN_OVF] <= 1'b1;
            if (deq_r && !out_fifo_rempty_n)
                err[ERR_RD_EMPTY] <= 1'b1;
            if (start_edge && (state == BUSY))
                err[ERR_START_BUSY] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ann_io_port.sv
// Directed bench for ann_io_port: scoreboard queues for both FIFO paths plus
// direct checks of flow control, control FSM, error flags and reset.
`timescale 1ns/1ps
module tb_ann_io_port;
    import ann_io_pkg::*;

    localparam int W         = 11;
    localparam int IN_DEPTH  = 16;
    localparam int OUT_DEPTH = 16;

    logic          io_clk = 1'b0;
    logic          io_rst;
    logic          in_fifo_wenq;
    logic [W-1:0]  in_fifo_wdata;
    logic          in_fifo_wfull_n;
    logic          out_fifo_deq;
    logic [W-1:0]  out_fifo_rdata;
    logic          out_fifo_rempty_n;
    logic          fsm_start, load_kdtree, send_best_arr;
    logic          fsm_done;
    logic [W-1:0]  core_rdata;
    logic          core_rvalid;
    logic          core_rdeq;
    logic [W-1:0]  core_wdata;
    logic          core_wenq;
    logic          core_wready;
    logic          core_start;
    logic [1:0]    core_mode;
    logic          core_done;
    logic [2:0]    err;
    state_t        fsm_state;

    int n_vec = 0;
    int n_bad = 0;
    int start_pulses = 0;
    logic [W-1:0] in_exp_q[$];
    logic [W-1:0] out_exp_q[$];

    ann_io_port #(.DATA_W(W), .IN_DEPTH(IN_DEPTH), .OUT_DEPTH(OUT_DEPTH)) dut (
        .io_clk            (io_clk),
        .io_rst            (io_rst),
        .in_fifo_wenq      (in_fifo_wenq),
        .in_fifo_wdata     (in_fifo_wdata),
        .in_fifo_wfull_n   (in_fifo_wfull_n),
        .out_fifo_deq      (out_fifo_deq),
        .out_fifo_rdata    (out_fifo_rdata),
        .out_fifo_rempty_n (out_fifo_rempty_n),
        .fsm_start         (fsm_start),
        .load_kdtree       (load_kdtree),
        .send_best_arr     (send_best_arr),
        .fsm_done          (fsm_done),
        .core_rdata        (core_rdata),
        .core_rvalid       (core_rvalid),
        .core_rdeq         (core_rdeq),
        .core_wdata        (core_wdata),
        .core_wenq         (core_wenq),
        .core_wready       (core_wready),
        .core_start        (core_start),
        .core_mode         (core_mode),
        .core_done         (core_done),
        .err               (err),
        .fsm_state         (fsm_state)
    );

    always #5 io_clk = ~io_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the expected queues whenever a word is handed over.
    always @(negedge io_clk) begin
        if (!io_rst) begin
            if (core_rdeq && core_rvalid) begin
                if (in_exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL core_rdata_extra: got 0x%0h, expected nothing", core_rdata);
                end else begin
                    check("core_rdata", 32'(core_rdata), 32'(in_exp_q.pop_front()));
                end
            end
            if (out_fifo_deq && out_fifo_rempty_n) begin
                if (out_exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL out_rdata_extra: got 0x%0h, expected nothing", out_fifo_rdata);
                end else begin
                    check("out_fifo_rdata", 32'(out_fifo_rdata), 32'(out_exp_q.pop_front()));
                end
            end
            if (core_start)
                start_pulses++;
        end
    end

    task automatic tick();
        @(posedge io_clk);
        #1;
    endtask

    task automatic host_deq();
        out_fifo_deq = 1'b1;
        tick();
        out_fifo_deq = 1'b0;
        tick();
    endtask

    task automatic pulse_start(input logic load, input logic send);
        load_kdtree   = load;
        send_best_arr = send;
        fsm_start     = 1'b1;
        tick();
        fsm_start     = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wfull_n"}, 32'(in_fifo_wfull_n), 32'd0);
        check({tag, "_out_rdata"}, 32'(out_fifo_rdata), 32'd0);
        check({tag, "_rempty_n"}, 32'(out_fifo_rempty_n), 32'd0);
        check({tag, "_fsm_done"}, 32'(fsm_done), 32'd0);
        check({tag, "_core_rdata"}, 32'(core_rdata), 32'd0);
        check({tag, "_core_rvalid"}, 32'(core_rvalid), 32'd0);
        check({tag, "_core_wready"}, 32'(core_wready), 32'd0);
        check({tag, "_core_start"}, 32'(core_start), 32'd0);
        check({tag, "_core_mode"}, 32'(core_mode), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_state"}, 32'(fsm_state), 32'(IDLE));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        io_rst = 1'b1;
        in_fifo_wenq = 1'b0;  in_fifo_wdata = '0;  out_fifo_deq = 1'b0;
        fsm_start = 1'b0;     load_kdtree = 1'b0;  send_best_arr = 1'b0;
        core_rdeq = 1'b0;     core_wdata = '0;     core_wenq = 1'b0;
        core_done = 1'b0;

        repeat (3) @(negedge io_clk);
        check_all_zero("reset");
        io_rst = 1'b0;
        tick();
        check("wfull_n_after_reset", 32'(in_fifo_wfull_n), 32'd1);
        check("wready_after_reset", 32'(core_wready), 32'd1);

        // Fill: host keeps writing through 17 words, core never pops.
        for (int i = 1; i <= 17; i++) begin
            in_fifo_wenq  = 1'b1;
            in_fifo_wdata = W'(i);
            if (i <= IN_DEPTH)
                in_exp_q.push_back(W'(i));
            tick();
            if (i == 13) check("wfull_n_after_13", 32'(in_fifo_wfull_n), 32'd1);
            if (i == 14) check("wfull_n_after_14", 32'(in_fifo_wfull_n), 32'd0);
            if (i == 17) check("err0_before_17th", 32'(err[0]), 32'd0);
        end
        in_fifo_wenq = 1'b0;
        tick();
        check("err0_after_17th", 32'(err[0]), 32'd1);
        check("head_after_fill", 32'(core_rdata), 32'h001);

        core_rdeq = 1'b1;
        repeat (IN_DEPTH) tick();
        core_rdeq = 1'b0;
        tick();
        check("rvalid_after_drain", 32'(core_rvalid), 32'd0);
        check("wfull_n_after_drain", 32'(in_fifo_wfull_n), 32'd1);

        // Simultaneous push and pop with one entry held.
        in_fifo_wenq = 1'b1;  in_fifo_wdata = W'(11'h0AA);  in_exp_q.push_back(W'(11'h0AA));
        tick();
        in_fifo_wenq = 1'b0;
        tick();
        tick();
        in_fifo_wenq = 1'b1;  in_fifo_wdata = W'(11'h0BB);  in_exp_q.push_back(W'(11'h0BB));
        tick();
        in_fifo_wenq = 1'b0;
        core_rdeq    = 1'b1;
        tick();
        core_rdeq    = 1'b0;
        check("pushpop_rvalid", 32'(core_rvalid), 32'd1);
        check("pushpop_head", 32'(core_rdata), 32'h0BB);
        core_rdeq = 1'b1;
        tick();
        core_rdeq = 1'b0;
        check("pushpop_count1", 32'(core_rvalid), 32'd0);
        check("in_queue_empty", 32'(in_exp_q.size()), 32'd0);

        // Output path.
        core_wenq = 1'b1;  core_wdata = W'(11'h7FF);  out_exp_q.push_back(W'(11'h7FF));
        tick();
        check("rempty_n_one_edge", 32'(out_fifo_rempty_n), 32'd0);
        core_wdata = W'(11'h000);  out_exp_q.push_back(W'(11'h000));
        tick();
        check("rempty_n_two_edges", 32'(out_fifo_rempty_n), 32'd1);
        check("out_rdata_first", 32'(out_fifo_rdata), 32'h7FF);
        core_wdata = W'(11'h5A5);  out_exp_q.push_back(W'(11'h5A5));
        tick();
        core_wenq = 1'b0;
        tick();
        for (int i = 0; i < 3; i++)
            host_deq();
        check("rempty_n_after_reads", 32'(out_fifo_rempty_n), 32'd0);
        check("err1_before_extra", 32'(err[1]), 32'd0);
        host_deq();
        tick();
        check("err1_after_extra", 32'(err[1]), 32'd1);
        check("out_queue_empty", 32'(out_exp_q.size()), 32'd0);

        // Start with load_kdtree, then a second start while busy.
        pulse_start(1'b1, 1'b0);
        check("start_not_yet", 32'(core_start), 32'd0);
        tick();
        check("start_pulse", 32'(core_start), 32'd1);
        check("mode_load", 32'(core_mode), 32'(MODE_LOAD));
        check("state_busy", 32'(fsm_state), 32'(BUSY));
        load_kdtree = 1'b0;
        tick();
        check("start_one_cycle", 32'(core_start), 32'd0);
        check("err2_clear", 32'(err[2]), 32'd0);
        pulse_start(1'b0, 1'b0);
        repeat (3) tick();
        check("err2_start_busy", 32'(err[2]), 32'd1);
        check("no_second_pulse", 32'(start_pulses), 32'd1);
        check("mode_held", 32'(core_mode), 32'(MODE_LOAD));

        // Done handling.
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        check("done_not_yet", 32'(fsm_done), 32'd0);
        tick();
        check("fsm_done_set", 32'(fsm_done), 32'd1);
        repeat (3) tick();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        repeat (2) tick();
        check("fsm_done_held", 32'(fsm_done), 32'd1);
        check("state_done", 32'(fsm_state), 32'(DONE));

        pulse_start(1'b0, 1'b1);
        tick();
        check("start_pulse_send", 32'(core_start), 32'd1);
        check("mode_send", 32'(core_mode), 32'(MODE_SEND));
        send_best_arr = 1'b0;
        tick();
        check("fsm_done_cleared", 32'(fsm_done), 32'd0);
        check("start_pulses_total", 32'(start_pulses), 32'd2);

        // Reset in the middle of a job with data in both FIFOs.
        in_fifo_wenq = 1'b1;  in_fifo_wdata = W'(11'h123);
        core_wenq    = 1'b1;  core_wdata    = W'(11'h456);
        tick();
        in_fifo_wenq = 1'b0;
        core_wenq    = 1'b0;
        repeat (2) tick();
        check("mid_rvalid", 32'(core_rvalid), 32'd1);
        check("mid_rempty_n", 32'(out_fifo_rempty_n), 32'd1);
        io_rst = 1'b1;
        #1;
        check_all_zero("midrst");
        repeat (2) @(negedge io_clk);
        check_all_zero("midrst_held");
        io_rst = 1'b0;
        tick();
        check("wfull_n_after_midrst", 32'(in_fifo_wfull_n), 32'd1);
        check("rvalid_after_midrst", 32'(core_rvalid), 32'd0);
        check("rempty_n_after_midrst", 32'(out_fifo_rempty_n), 32'd0);

        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
